// File: rtl/ft64_icompressor_if.sv
// ft64_icompressor_if
//   Handshake bundle for the FT64 instruction compressor.
//   Input stream : i_valid / i_ready / i_instr[47:0]  (one instruction per beat)
//   Output stream: o_valid / o_ready / o_parcel[15:0] (one 16-bit parcel per beat)
//                  plus o_last (final parcel of instruction) and o_cmp
//                  (instruction was compressed).
//   master: the side that supplies instructions and sinks parcels.
//   slave : the compressor itself.
interface ft64_icompressor_if;
  logic        i_valid;
  logic        i_ready;
  logic [47:0] i_instr;
  logic        o_valid;
  logic        o_ready;
  logic [15:0] o_parcel;
  logic        o_last;
  logic        o_cmp;

  modport master (
    output i_valid, i_instr, o_ready,
    input  i_ready, o_valid, o_parcel, o_last, o_cmp
  );

  modport slave (
    input  i_valid, i_instr, o_ready,
    output i_ready, o_valid, o_parcel, o_last, o_cmp
  );
endinterface

// File: rtl/ft64_icompressor.sv
// ft64_icompressor
//   Streaming FT64 instruction compressor. Accepts one instruction per input
//   handshake and emits it as 16-bit parcels, low parcel first. A fixed set of
//   32-bit forms (ADDI, LDI, MOV, SP-relative LW/SW, BRA) is re-encoded into a
//   single compressed parcel; everything else passes through unchanged.
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   bus       ft64_icompressor_if.slave (instruction in / parcel out)
//   stat_in   wrapping count of accepted instructions
//   stat_cmp  wrapping count of compressed instructions
module ft64_icompressor #(
  parameter int unsigned CNTW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ft64_icompressor_if.slave    bus,
  output logic [CNTW-1:0]      stat_in,
  output logic [CNTW-1:0]      stat_cmp
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  // Opcode / function encodings of the compressible forms.
  localparam logic [5:0] OP_R2   = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h04;
  localparam logic [5:0] OP_ORI  = 6'h09;
  localparam logic [5:0] OP_LW   = 6'h20;
  localparam logic [5:0] OP_SW   = 6'h24;
  localparam logic [5:0] OP_BCC  = 6'h30;
  localparam logic [5:0] FN_MOV  = 6'h22;

  logic [0:0]  state;
  logic [47:0] hold;
  logic [1:0]  idx;
  logic [1:0]  lastidx;
  logic        cmp_q;

  // Compressed parcel: c[15:12]=key[4:1], c[11:8]=F[4:1], c[7]=0,
  // c[6]=key[0], c[5]=F[0], c[4:0]=low field.
  function automatic logic [15:0] pack(input logic [4:0] key,
                                       input logic [4:0] f,
                                       input logic [4:0] low);
    return {key[4:1], f[4:1], 1'b0, key[0], f[0], low};
  endfunction

  logic [5:0]  op;
  logic [4:0]  rt, ra;
  logic [13:0] imm;
  logic        imm5ok, memok, braok;
  logic        cok;
  logic [15:0] cpar;
  logic [1:0]  nlast;

  always_comb begin
    op   = bus.i_instr[5:0];
    rt   = bus.i_instr[17:13];
    ra   = bus.i_instr[12:8];
    imm  = bus.i_instr[31:18];
    // A value is the sign-extension of its low k bits when every bit from
    // k-1 upward is identical.
    imm5ok = (imm[13:4] == '0) || (imm[13:4] == '1);
    memok  = (imm[2:0] == 3'd4) && ((imm[13:7] == '0) || (imm[13:7] == '1));
    braok  = (bus.i_instr[31] == bus.i_instr[30]);
    cok    = 1'b0;
    cpar   = '0;
    if (bus.i_instr[7:6] == 2'b10) begin
      if (op == OP_ADDI && rt == ra && ra != 5'd0 && ra != 5'd31 && imm5ok) begin
        cok  = 1'b1;
        cpar = pack(5'b00000, imm[4:0], ra);
      end else if (op == OP_ORI && ra == 5'd0 && rt != 5'd0 && imm5ok) begin
        cok  = 1'b1;
        cpar = pack(5'b00010, imm[4:0], rt);
      end else if (op == OP_R2 && bus.i_instr[31:26] == FN_MOV &&
                   bus.i_instr[25:23] == 3'd7 && bus.i_instr[22:18] == 5'd0) begin
        cok  = 1'b1;
        cpar = pack(5'b00001, rt, ra);
      end else if ((op == OP_LW || op == OP_SW) && ra == 5'd31 && memok) begin
        cok  = 1'b1;
        cpar = pack((op == OP_LW) ? 5'b01011 : 5'b10011, imm[7:3], rt);
      end else if (op == OP_BCC && bus.i_instr[20:18] == 3'd0 &&
                   bus.i_instr[17:8] == 10'd0 && braok) begin
        cok  = 1'b1;
        cpar = pack(5'b01110, bus.i_instr[30:26], bus.i_instr[25:21]);
      end
    end
    // Index of the final parcel for the incoming instruction.
    if (!bus.i_instr[7])           nlast = 2'd0;
    else if (bus.i_instr[6])       nlast = 2'd2;
    else                           nlast = cok ? 2'd0 : 2'd1;
  end

  logic last;
  logic accept;

  always_comb begin
    last          = (idx == lastidx);
    bus.o_valid   = (state == EMIT);
    bus.i_ready   = (state == IDLE) || (bus.o_ready && last);
    accept        = bus.i_valid && bus.i_ready;
    bus.o_last    = (state == EMIT) && last;
    bus.o_cmp     = (state == EMIT) && cmp_q;
    bus.o_parcel  = '0;
    if (state == EMIT) begin
      case (idx)
        2'd0:    bus.o_parcel = hold[15:0];
        2'd1:    bus.o_parcel = hold[31:16];
        default: bus.o_parcel = hold[47:32];
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      hold     <= '0;
      idx      <= '0;
      lastidx  <= '0;
      cmp_q    <= 1'b0;
      stat_in  <= '0;
      stat_cmp <= '0;
    end else begin
      if (accept) begin
        // A compressed instruction is stored as its single parcel so the
        // output mux is the same for every form.
        hold     <= cok ? {32'd0, cpar} : bus.i_instr;
        cmp_q    <= cok;
        lastidx  <= nlast;
        idx      <= '0;
        state    <= EMIT;
        stat_in  <= stat_in + CNTW'(1);
        if (cok) stat_cmp <= stat_cmp + CNTW'(1);
      end else if (state == EMIT && bus.o_ready) begin
        if (last) begin
          state <= IDLE;
          idx   <= '0;
        end else begin
          idx <= idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ft64_icompressor.sv
// tb_ft64_icompressor
//   Directed bench for ft64_icompressor: reset values, each compressed form,
//   pass-through of 16/32/48-bit instructions, back-to-back streaming,
//   backpressure, mid-instruction reset and statistics counter wrap.
module tb_ft64_icompressor;
  logic clk;
  logic rst_ni;
  logic [3:0] stat_in;
  logic [3:0] stat_cmp;
  int ntests;
  int nfail;

  ft64_icompressor_if bus ();

  ft64_icompressor #(.CNTW(4)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .bus      (bus.slave),
    .stat_in  (stat_in),
    .stat_cmp (stat_cmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] parcel,
                           input logic lst, input logic cmp);
    check({tag, ".valid"},  32'(bus.o_valid), 32'd1);
    check({tag, ".parcel"}, 32'(bus.o_parcel), 32'(parcel));
    check({tag, ".last"},   32'(bus.o_last), 32'(lst));
    check({tag, ".cmp"},    32'(bus.o_cmp), 32'(cmp));
  endtask

  // Hand-encoded instructions
  localparam logic [47:0] I_ADDI553  = 48'h0000_000C_A584; // ADDI r5,r5,#3
  localparam logic [47:0] I_ADDI563  = 48'h0000_000C_A684; // ADDI r5,r6,#3
  localparam logic [47:0] I_ADDI5516 = 48'h0000_0040_A584; // ADDI r5,r5,#16
  localparam logic [47:0] I_MOV      = 48'h0000_8B80_6782; // MOV Rt=3,Ra=7
  localparam logic [47:0] I_BRA      = 48'h0000_FFE0_00B0; // BRA disp -1
  localparam logic [47:0] I_LW       = 48'h0000_0030_5FA0; // LW r2,12(sp)
  localparam logic [47:0] I_SW       = 48'h0000_FFF0_7FA4; // SW r3,-4(sp)
  localparam logic [47:0] I_LDI      = 48'h0000_FFF8_8089; // LDI r4,#-2
  localparam logic [47:0] I_C16      = 48'h0000_0000_1234; // 16-bit form
  localparam logic [47:0] I_W48      = 48'h1234_5678_9ACF; // 48-bit form

  initial begin
    ntests = 0;
    nfail  = 0;
    rst_ni = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_instr = '0;
    bus.o_ready = 1'b1;
    tick; tick;

    check("rst.valid",  32'(bus.o_valid), 32'd0);
    check("rst.parcel", 32'(bus.o_parcel), 32'd0);
    check("rst.last",   32'(bus.o_last), 32'd0);
    check("rst.cmp",    32'(bus.o_cmp), 32'd0);
    check("rst.ready",  32'(bus.i_ready), 32'd1);
    check("rst.stin",   32'(stat_in), 32'd0);
    check("rst.stcmp",  32'(stat_cmp), 32'd0);
    rst_ni = 1'b1;
    tick;

    // Single compressed ADDI
    bus.i_valid = 1'b1; bus.i_instr = I_ADDI553;
    tick;
    check_out("addi", 16'h0125, 1'b1, 1'b1);
    check("addi.stcmp", 32'(stat_cmp), 32'd1);
    bus.i_valid = 1'b0;
    tick;
    check("addi.idle", 32'(bus.o_valid), 32'd0);

    // Back-to-back single-parcel instructions, one per cycle
    bus.i_valid = 1'b1; bus.i_instr = I_MOV;
    tick;
    check_out("mov", 16'h0167, 1'b1, 1'b1);
    check("mov.iready", 32'(bus.i_ready), 32'd1);
    bus.i_instr = I_BRA;
    tick;
    check_out("bra", 16'h7F3F, 1'b1, 1'b1);
    bus.i_instr = I_LW;
    tick;
    check_out("lw", 16'h5062, 1'b1, 1'b1);
    bus.i_instr = I_SW;
    tick;
    check_out("sw", 16'h9F63, 1'b1, 1'b1);
    bus.i_instr = I_LDI;
    tick;
    check_out("ldi", 16'h1F04, 1'b1, 1'b1);
    bus.i_instr = I_C16;
    tick;
    check_out("c16", 16'h1234, 1'b1, 1'b0);
    bus.i_valid = 1'b0;
    tick;
    check("b2b.idle", 32'(bus.o_valid), 32'd0);
    check("b2b.stin", 32'(stat_in), 32'd7);
    check("b2b.stcmp", 32'(stat_cmp), 32'd6);

    // Non-compressible ADDIs, second one taken seamlessly on last parcel
    bus.i_valid = 1'b1; bus.i_instr = I_ADDI563;
    tick;
    check_out("nc1.p0", 16'hA684, 1'b0, 1'b0);
    check("nc1.iready0", 32'(bus.i_ready), 32'd0);
    bus.i_instr = I_ADDI5516;
    tick;
    check_out("nc1.p1", 16'h000C, 1'b1, 1'b0);
    check("nc1.iready1", 32'(bus.i_ready), 32'd1);
    tick;
    check_out("nc2.p0", 16'hA584, 1'b0, 1'b0);
    bus.i_valid = 1'b0;
    tick;
    check_out("nc2.p1", 16'h0040, 1'b1, 1'b0);
    tick;
    check("nc.idle", 32'(bus.o_valid), 32'd0);

    // 48-bit with o_ready pattern 1,0,0,1,1
    bus.i_valid = 1'b1; bus.i_instr = I_W48;
    tick;
    bus.i_valid = 1'b0;
    check_out("w48.p0", 16'h9ACF, 1'b0, 1'b0);
    check("w48.iready0", 32'(bus.i_ready), 32'd0);
    tick;
    bus.o_ready = 1'b0;
    #1;
    check_out("w48.p1a", 16'h5678, 1'b0, 1'b0);
    check("w48.iready1", 32'(bus.i_ready), 32'd0);
    tick;
    check_out("w48.p1b", 16'h5678, 1'b0, 1'b0);
    check("w48.iready2", 32'(bus.i_ready), 32'd0);
    tick;
    check_out("w48.p1c", 16'h5678, 1'b0, 1'b0);
    bus.o_ready = 1'b1;
    tick;
    check_out("w48.p2", 16'h1234, 1'b1, 1'b0);
    check("w48.iready3", 32'(bus.i_ready), 32'd1);
    tick;
    check("w48.idle", 32'(bus.o_valid), 32'd0);
    check("w48.stin", 32'(stat_in), 32'd10);
    check("w48.stcmp", 32'(stat_cmp), 32'd6);

    // Reset asserted after the first parcel of a 2-parcel instruction
    bus.i_valid = 1'b1; bus.i_instr = I_ADDI563;
    tick;
    bus.i_valid = 1'b0;
    check_out("mrst.p0", 16'hA684, 1'b0, 1'b0);
    rst_ni = 1'b0;
    #1;
    check("mrst.valid",  32'(bus.o_valid), 32'd0);
    check("mrst.parcel", 32'(bus.o_parcel), 32'd0);
    check("mrst.ready",  32'(bus.i_ready), 32'd1);
    check("mrst.stin",   32'(stat_in), 32'd0);
    check("mrst.stcmp",  32'(stat_cmp), 32'd0);
    tick;
    rst_ni = 1'b1;
    tick;
    check("mrst.drop", 32'(bus.o_valid), 32'd0);

    // 2^CNTW+1 accepted instructions wrap the counters to 1
    bus.i_valid = 1'b1; bus.i_instr = I_ADDI553;
    repeat (17) tick;
    bus.i_valid = 1'b0;
    check("wrap.stin",  32'(stat_in), 32'd1);
    check("wrap.stcmp", 32'(stat_cmp), 32'd1);
    tick;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/ft64_icompressor.md
# ft64_icompressor

Streaming instruction compressor for the FT64 code-generation and loader path. It accepts one FT64 instruction per handshake and re-encodes a fixed subset of 32-bit forms into 16-bit compressed parcels. Any instruction it cannot compress passes through unchanged. Output is a stream of 16-bit parcels, low parcel first, ready to be written to instruction memory.

## Interface
- `CNTW`, default 16: width of the statistics counters.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  input instruction valid.
- `i_ready`  out  1  block can accept an instruction this cycle.
- `i_instr`  in  48  instruction; the length class is taken from bits [7:6].
- `o_valid`  out  1  parcel valid.
- `o_ready`  in  1  downstream accepts the parcel.
- `o_parcel`  out  16  parcel data.
- `o_last`  out  1  final parcel of the current instruction.
- `o_cmp`  out  1  current instruction was compressed by this block.
- `stat_in`  out  CNTW  count of instructions accepted; wraps.
- `stat_cmp`  out  CNTW  count of instructions compressed; wraps.

## Operation
- **Length class from `[7:6]`:**
  - `2'b10`: 32-bit, compression candidate.
  - `2'b11`: 48-bit, pass-through as 3 parcels.
  - `2'b0x`: already 16-bit, pass-through as 1 parcel.
- **Compressed parcel layout:** `c[7]=0` always. The key is `{c[15:12], c[6]}`. The 5-bit field `F = {c[11:8], c[5]}`. Compressed rules, first match wins:
  - **ADDI:** `[5:0]=ADDI`, Rt==Ra (Rt in `[17:13]`, Ra in `[12:8]`), Ra≠0, Ra≠31, imm `[31:18]` is the sign-extension of 5 bits. Produces key 00000, `c[4:0]=Ra`, `F=imm[4:0]`.
  - **LDI:** `ORI`, Ra=0, Rt≠0, imm fits in 5 bits signed. Produces key 00010, `c[4:0]=Rt`, `F=imm[4:0]`.
  - **MOV:** `[5:0]=6'h02`, `[31:26]=MOV`, `[25:23]=7`, `[22:18]=0`. Produces key 00001, `c[4:0]=Ra`, `F=Rt`.
  - **LW/SW SP-relative:** `Lx`/`Sx`, Ra=31, `imm[2:0]=3'd4`, `imm[13:3]` is the sign-extension of 5 bits. Produces keys 01011 (LW) and 10011 (SW), `c[4:0]=Rt`, `F=imm[7:3]`.
  - **BRA:** `Bcc`, `[20:18]=0`, `[17:8]=0`, `[31:21]` is the sign-extension of 10 bits. Produces key 01110, `{c[11:8], c[5:0]} = [30:21]`.
- **Uncompressed 32-bit instructions** emit 2 parcels: `[15:0]`, then `[31:16]`.
- **Ignored bits:** `[47:32]` of a 32-bit candidate is ignored.
- **State machine:** one holding register plus states IDLE and EMIT, with parcel index `idx` (0..2) and parcel count `n` (1..3).
  - IDLE: `i_ready=1`. On `i_valid`, capture `i_instr`, compute `n` and `o_cmp`, set `idx=0`, go to EMIT.
  - EMIT: `o_valid=1`. On `o_ready`, `idx` increments.
  - On the last parcel (`idx==n-1`) with `o_ready`: if `i_valid`, capture the next instruction and stay in EMIT; otherwise go to IDLE.
  - `i_ready = IDLE || (EMIT && o_ready && o_last)`.
- **Output stability:** `o_parcel`, `o_last` and `o_cmp` come from registered state plus combinational selection. They are stable while `o_valid && !o_ready`.
- **Counters:** `stat_in` increments on every input handshake. `stat_cmp` increments when the captured instruction compresses. Both wrap modulo 2^CNTW.

## Timing
- **Reset (asynchronous, `rst_ni=0`):** state IDLE, `o_valid=0`, `o_parcel=0`, `o_last=0`, `o_cmp=0`, `idx=0`, both stats 0. Assertion mid-instruction drops the remaining parcels.
- **Latency:** input handshake in cycle N gives the first parcel with `o_valid` in cycle N+1.
- **Throughput with `o_ready` held high:**
  - Back-to-back compressible or 16-bit instructions: 1 per cycle, no bubble.
  - 32-bit uncompressed: 1 per 2 cycles.
  - 48-bit: 1 per 3 cycles.
- **Backpressure:** with `o_ready=0`, state, `idx` and outputs hold and `i_ready=0` while in EMIT.
- **Simultaneous events:** last-parcel acceptance and a new input in the same cycle produce a seamless transition with no IDLE cycle.

## Test plan
- **Compress ADDI:** ADDI r5,r5,#3 (`[17:13]=5`, `[12:8]=5`, imm=3) -> one parcel 16'h0125, `o_last=1`, `o_cmp=1`, `stat_cmp=1`.
- **Compress MOV and BRA:** MOV Rt=3, Ra=7 -> 16'h0167. BRA with disp=-1 (`[31:21]=11'h7FF`) -> 16'h7F3F. Each is 1 parcel.
- **Compress SP load:** LW r2 with imm=14'h000C, Ra=31 -> 16'h5062.
- **Non-compressible:**
  - ADDI r5,r6,#3 -> two parcels `[15:0]` then `[31:16]`, `o_cmp=0`, second parcel `o_last=1`.
  - ADDI r5,r5,#16 (out of range) -> also 2 parcels.
- **Backpressure:** a 48-bit instruction with `o_ready` toggled 1,0,0,1,1 -> exactly 3 parcels in order, held values during stalls, `i_ready=0` until the last parcel is accepted.
- **Reset and counters:** assert `rst_ni` after the first parcel of a 2-parcel instruction -> `o_valid=0` immediately, state IDLE, stats 0. Separately, 2^CNTW+1 accepted instructions -> `stat_in=1`.
